// File: rtl/square_wave_analyzer_if.sv
// Stimulus/result bundle for square_wave_analyzer: the probed wave and soft restart in, measurements out.
// Purely combinational wiring, no flow control: results are level-held until the next update.
interface square_wave_analyzer_if #(
  parameter int CNT_W = 16
);
  logic             sig_in;
  logic             clear;
  logic             meas_valid;
  logic [CNT_W-1:0] period;
  logic [CNT_W-1:0] high_time;
  logic [7:0]       meas_count;
  logic             no_signal;

  modport master (
    output sig_in, clear,
    input  meas_valid, period, high_time, meas_count, no_signal
  );

  modport slave (
    input  sig_in, clear,
    output meas_valid, period, high_time, meas_count, no_signal
  );
endinterface

// File: rtl/square_wave_analyzer.sv
// Measures period and high time of an async square wave in clk cycles; flags loss of signal on timeout.
// meas_valid pulses SYNC_N+1 clk after the closing rise reaches the synchronizer; no backpressure, results hold.
module square_wave_analyzer #(
  parameter int CNT_W   = 16,
  parameter int TIMEOUT = 1000,
  parameter int SYNC_N  = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  square_wave_analyzer_if.slave bus
);

  typedef enum logic [1:0] {IDLE, HIGH, LOW} state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] TO_VAL  = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_t           state_q, state_d;
  logic [SYNC_N-1:0] sync_q;
  logic             s, s_d;
  logic             rise, fall, any_edge, timeout;

  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic [CNT_W-1:0] hi_q, hi_d;
  logic [CNT_W-1:0] idle_q, idle_d;
  logic [CNT_W-1:0] period_q, period_d;
  logic [CNT_W-1:0] high_q, high_d;
  logic [7:0]       mc_q, mc_d;
  logic             mv_q, mv_d;
  logic             ns_q, ns_d;

  assign s        = sync_q[SYNC_N-1];
  assign rise     = s & ~s_d;
  assign fall     = ~s & s_d;
  assign any_edge = rise | fall;
  // An edge in the same cycle always wins over the timeout.
  assign timeout  = ~any_edge && (idle_q == TO_LAST);
  assign cnt_inc  = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      s_d    <= 1'b0;
    end else if (bus.clear) begin
      sync_q <= '0;
      s_d    <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_N-2:0], bus.sig_in};
      s_d    <= s;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (bus.clear) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    if (rise) state_d = HIGH;
        HIGH:    if (fall) state_d = LOW;  else if (timeout) state_d = IDLE;
        LOW:     if (rise) state_d = HIGH; else if (timeout) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    cnt_d    = cnt_q;
    hi_d     = hi_q;
    period_d = period_q;
    high_d   = high_q;
    mc_d     = mc_q;
    mv_d     = 1'b0;
    ns_d     = ns_q;
    if (any_edge)            idle_d = '0;
    else if (idle_q == TO_VAL) idle_d = idle_q;
    else                     idle_d = idle_q + 1'b1;

    if (bus.clear) begin
      cnt_d    = '0;
      hi_d     = '0;
      period_d = '0;
      high_d   = '0;
      mc_d     = '0;
      ns_d     = 1'b0;
      idle_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (rise)         cnt_d = CNT_ONE;
          else if (timeout) ns_d  = 1'b1;
        end
        HIGH: begin
          if (fall) begin
            hi_d  = cnt_q;
            cnt_d = cnt_inc;
          end else if (timeout) begin
            ns_d  = 1'b1;
            cnt_d = '0;
          end else begin
            cnt_d = cnt_inc;
          end
        end
        LOW: begin
          if (rise) begin
            period_d = cnt_q;
            high_d   = hi_q;
            mv_d     = 1'b1;
            mc_d     = mc_q + 8'd1;
            ns_d     = 1'b0;
            cnt_d    = CNT_ONE;
          end else if (timeout) begin
            ns_d  = 1'b1;
            cnt_d = '0;
          end else begin
            cnt_d = cnt_inc;
          end
        end
        default: cnt_d = '0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q    <= '0;
      hi_q     <= '0;
      idle_q   <= '0;
      period_q <= '0;
      high_q   <= '0;
      mc_q     <= '0;
      mv_q     <= 1'b0;
      ns_q     <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      hi_q     <= hi_d;
      idle_q   <= idle_d;
      period_q <= period_d;
      high_q   <= high_d;
      mc_q     <= mc_d;
      mv_q     <= mv_d;
      ns_q     <= ns_d;
    end
  end

  assign bus.meas_valid = mv_q;
  assign bus.period     = period_q;
  assign bus.high_time  = high_q;
  assign bus.meas_count = mc_q;
  assign bus.no_signal  = ns_q;

endmodule

// File: tb/tb_square_wave_analyzer.sv
// Directed bench for square_wave_analyzer: duty-cycle table plus timeout, reset, clear, wrap and saturation sequences.
module tb_square_wave_analyzer;

  typedef struct {
    int hi;
    int lo;
    int n;
    int exp_per;
    int exp_hi;
    int exp_delta;
  } vec_t;

  logic clk;
  logic rst_n;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int last_t   = 0;
  int prev_t   = 0;
  int mv_n     = 0;
  int mv4_n    = 0;
  logic ns_at_mv = 1'b1;
  bit phase6   = 1'b0;
  bit ns4_hit  = 1'b0;

  square_wave_analyzer_if #(.CNT_W(16)) bus ();
  square_wave_analyzer_if #(.CNT_W(4))  bus4 ();

  square_wave_analyzer #(.CNT_W(16), .TIMEOUT(50), .SYNC_N(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  square_wave_analyzer #(.CNT_W(4), .TIMEOUT(14), .SYNC_N(2)) dut4 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus4)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (bus.meas_valid === 1'b1) begin
      mv_n++;
      prev_t   = last_t;
      last_t   = cyc;
      ns_at_mv = bus.no_signal;
    end
    if (bus4.meas_valid === 1'b1) mv4_n++;
    if (phase6 && bus4.no_signal !== 1'b0) ns4_hit = 1'b1;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_sig(input int sel, input logic v);
    if (sel == 0) bus.sig_in = v;
    else          bus4.sig_in = v;
  endtask

  task automatic wave(input int sel, input int hi, input int lo, input int n);
    for (int k = 0; k < n; k++) begin
      set_sig(sel, 1'b1);
      repeat (hi) tick();
      set_sig(sel, 1'b0);
      repeat (lo) tick();
    end
  endtask

  initial begin
    vec_t tbl[5];
    int   base;
    int   exp_mc;

    tbl[0] = '{5, 5, 6, 10, 5, 5};
    tbl[1] = '{3, 7, 4, 10, 3, 4};
    tbl[2] = '{1, 1, 6,  2, 1, 6};
    tbl[3] = '{2, 6, 4,  8, 2, 4};
    tbl[4] = '{7, 2, 3,  9, 7, 3};

    rst_n = 1'b1;
    bus.sig_in = 1'b0;  bus.clear = 1'b0;
    bus4.sig_in = 1'b0; bus4.clear = 1'b0;
    #1 rst_n = 1'b0;
    #19;
    chk("rst_meas_valid", bus.meas_valid, 0);
    chk("rst_period",     bus.period, 0);
    chk("rst_high_time",  bus.high_time, 0);
    chk("rst_meas_count", bus.meas_count, 0);
    chk("rst_no_signal",  bus.no_signal, 0);
    #3 rst_n = 1'b1;

    // Line stuck from reset: small instance times out after exactly 14 cycles.
    repeat (13) tick();
    chk("stuck_ns_before", bus4.no_signal, 0);
    tick();
    chk("stuck_ns_at", bus4.no_signal, 1);

    exp_mc = 0;
    for (int i = 0; i < 5; i++) begin
      base = mv_n;
      wave(0, tbl[i].hi, tbl[i].lo, tbl[i].n);
      repeat (6) tick();
      exp_mc = exp_mc + tbl[i].exp_delta;
      chk($sformatf("v%0d_period", i),    bus.period, tbl[i].exp_per);
      chk($sformatf("v%0d_high", i),      bus.high_time, tbl[i].exp_hi);
      chk($sformatf("v%0d_events", i),    mv_n - base, tbl[i].exp_delta);
      chk($sformatf("v%0d_count", i),     bus.meas_count, exp_mc);
      chk($sformatf("v%0d_no_signal", i), bus.no_signal, 0);
      if (i == 0) chk("v0_spacing", last_t - prev_t, 10);
    end

    // Timeout with line held high.
    wave(0, 4, 4, 2);
    bus.sig_in = 1'b1;
    repeat (52) tick();
    exp_mc = exp_mc + 3;
    chk("to_ns_before", bus.no_signal, 0);
    tick();
    chk("to_ns_at", bus.no_signal, 1);
    chk("to_period_hold", bus.period, 8);
    chk("to_high_hold", bus.high_time, 4);
    chk("to_count", bus.meas_count, exp_mc);

    base = mv_n;
    bus.sig_in = 1'b0; repeat (3) tick();
    bus.sig_in = 1'b1; repeat (3) tick();
    bus.sig_in = 1'b0; repeat (3) tick();
    chk("restart_armed_events", mv_n - base, 0);
    chk("restart_ns_still", bus.no_signal, 1);
    bus.sig_in = 1'b1; repeat (6) tick();
    exp_mc = exp_mc + 1;
    chk("restart_events", mv_n - base, 1);
    chk("restart_ns_at_mv", ns_at_mv, 0);
    chk("restart_period", bus.period, 6);
    chk("restart_high", bus.high_time, 3);
    chk("restart_count", bus.meas_count, exp_mc);

    // Async reset in the middle of a low phase.
    bus.sig_in = 1'b0; repeat (5) tick();
    #2 rst_n = 1'b0;
    #1;
    chk("arst_period", bus.period, 0);
    chk("arst_high", bus.high_time, 0);
    chk("arst_count", bus.meas_count, 0);
    chk("arst_valid", bus.meas_valid, 0);
    #10 rst_n = 1'b1;
    tick();
    base = mv_n;
    bus.sig_in = 1'b1; repeat (3) tick();
    bus.sig_in = 1'b0; repeat (3) tick();
    chk("arst_armed_events", mv_n - base, 0);
    bus.sig_in = 1'b1; repeat (6) tick();
    chk("arst_first_events", mv_n - base, 1);
    chk("arst_first_period", bus.period, 6);
    chk("arst_first_count", bus.meas_count, 1);

    // Clear coincident with a rise that would otherwise close a measurement.
    bus.sig_in = 1'b0; repeat (5) tick();
    base = mv_n;
    bus.sig_in = 1'b1;
    tick(); tick();
    bus.clear = 1'b1;
    tick();
    bus.clear = 1'b0;
    chk("clr_valid", bus.meas_valid, 0);
    chk("clr_count", bus.meas_count, 0);
    chk("clr_period", bus.period, 0);
    repeat (3) tick();
    bus.sig_in = 1'b0; repeat (4) tick();
    bus.sig_in = 1'b1; repeat (6) tick();
    chk("clr_events", mv_n - base, 1);
    chk("clr_next_period", bus.period, 7);
    chk("clr_next_high", bus.high_time, 3);
    chk("clr_next_count", bus.meas_count, 1);

    // meas_count wrap.
    bus.sig_in = 1'b0; repeat (6) tick();
    wave(0, 1, 1, 254);
    repeat (6) tick();
    chk("wrap_255", bus.meas_count, 255);
    bus.clear = 1'b1; tick(); bus.clear = 1'b0;
    chk("wrap_clear", bus.meas_count, 0);
    base = mv_n;
    wave(0, 1, 1, 257);
    repeat (6) tick();
    chk("wrap_events", mv_n - base, 256);
    chk("wrap_zero", bus.meas_count, 0);

    // Counter saturation on the narrow instance.
    bus4.clear = 1'b1; tick(); bus4.clear = 1'b0;
    chk("sat_ns_cleared", bus4.no_signal, 0);
    phase6 = 1'b1;
    base = mv4_n;
    wave(1, 12, 10, 3);
    bus4.sig_in = 1'b1;
    repeat (4) tick();
    phase6 = 1'b0;
    chk("sat_period", bus4.period, 15);
    chk("sat_high", bus4.high_time, 12);
    chk("sat_count", bus4.meas_count, 3);
    chk("sat_events", mv4_n - base, 3);
    chk("sat_no_timeout", ns4_hit, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
